// File: rtl/picnic_seed_pkg.sv
// Shared widths and request-FSM state type for the inseed dispatch path.
package picnic_seed_pkg;
  localparam int SEED_W         = 256;
  localparam int SEEDS_PER_TREE = 4;
  localparam int INSEEDS_W      = 1024;
  localparam int TREE_IDX_W     = 8;
  localparam int SEED_IDX_W     = 10;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    REQ,
    DROP
  } req_state_t;
endpackage

// File: rtl/inseed_slot_buffer.sv
// Two-slot ping-pong store of 1024-bit tree results, read out one 256-bit inseed at a time.
module inseed_slot_buffer
  import picnic_seed_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [INSEEDS_W-1:0]  wr_data,
  input  logic [TREE_IDX_W-1:0] wr_tree,
  input  logic                  rd_pop,
  output logic                  wr_free,
  output logic                  rd_valid,
  output logic [SEED_W-1:0]     rd_seed,
  output logic [TREE_IDX_W-1:0] rd_tree,
  output logic [1:0]            rd_k
);
  logic [INSEEDS_W-1:0]  mem [2];
  logic [TREE_IDX_W-1:0] tag [2];
  logic [1:0]            full;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            k;
  logic                  rd_free;

  assign wr_free  = !full[wr_ptr];
  assign rd_valid = full[rd_ptr];
  // The last inseed of a slot releases it; a write never targets the slot being read.
  assign rd_free  = rd_pop && rd_valid && (k == 2'(SEEDS_PER_TREE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      tag[0] <= '0;
      tag[1] <= '0;
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      k      <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        tag[wr_ptr] <= wr_tree;
        wr_ptr      <= ~wr_ptr;
      end
      for (int i = 0; i < 2; i++) begin
        if (wr_en && (wr_ptr == 1'(i)))        full[i] <= 1'b1;
        else if (rd_free && (rd_ptr == 1'(i))) full[i] <= 1'b0;
      end
      if (rd_pop && rd_valid) begin
        k <= k + 2'd1;
        if (rd_free) rd_ptr <= ~rd_ptr;
      end
    end
  end

  // k=0 is the most significant word of the tree result.
  always_comb begin
    rd_seed = '0;
    if (rd_valid) begin
      case (k)
        2'd0:    rd_seed = mem[rd_ptr][1023:768];
        2'd1:    rd_seed = mem[rd_ptr][767:512];
        2'd2:    rd_seed = mem[rd_ptr][511:256];
        default: rd_seed = mem[rd_ptr][255:0];
      endcase
    end
  end

  assign rd_tree = rd_valid ? tag[rd_ptr] : '0;
  assign rd_k    = rd_valid ? k : '0;
endmodule

// File: rtl/inseed_dispatcher.sv
// Requests seed trees one at a time and streams their inseeds downstream while the next tree expands.
module inseed_dispatcher
  import picnic_seed_pkg::*;
#(
  parameter int NUM_TREES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_start,
  output logic                  tree_start,
  output logic [TREE_IDX_W-1:0] tree_t,
  input  logic                  tree_set_end,
  input  logic [INSEEDS_W-1:0]  inseeds,
  output logic                  seed_valid,
  input  logic                  seed_ready,
  output logic [SEED_W-1:0]     seed_data,
  output logic [SEED_IDX_W-1:0] seed_index,
  output logic                  seed_last,
  output logic                  busy,
  output logic                  done,
  output req_state_t            req_state
);
  localparam int CNT_W = TREE_IDX_W + 1;
  localparam logic [CNT_W-1:0]      TREES     = CNT_W'(NUM_TREES);
  localparam logic [TREE_IDX_W-1:0] LAST_TREE = TREE_IDX_W'(NUM_TREES - 1);

  req_state_t            state;
  req_state_t            next_state;
  logic [CNT_W-1:0]      tree_cnt;
  logic                  slot_free;
  logic                  capture;
  logic                  fire;
  logic                  finish;
  logic [TREE_IDX_W-1:0] rd_tree;
  logic [1:0]            rd_k;

  // Downstream handshake: a transfer happens on a rising edge where seed_valid and
  // seed_ready are both high; while seed_valid=1 the payload holds until that transfer.
  assign capture = (state == REQ) && tree_set_end;
  assign fire    = seed_valid && seed_ready;
  assign finish  = fire && seed_last;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (run_start) next_state = ARB;
      // Waiting for tree_set_end low keeps the request from re-rising after a reset.
      ARB:     if (slot_free && (tree_cnt < TREES) && !tree_set_end) next_state = REQ;
      REQ:     if (tree_set_end) next_state = DROP;
      DROP:    if (!tree_set_end) next_state = ARB;
      default: next_state = IDLE;
    endcase
    if (finish) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tree_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= next_state;
      done  <= finish;
      if ((state == IDLE) && run_start) begin
        tree_cnt <= '0;
        busy     <= 1'b1;
      end else if (finish) begin
        tree_cnt <= '0;
        busy     <= 1'b0;
      end else if (capture) begin
        tree_cnt <= tree_cnt + CNT_W'(1);
      end
    end
  end

  inseed_slot_buffer u_slots (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (capture),
    .wr_data  (inseeds),
    .wr_tree  (tree_t),
    .rd_pop   (fire),
    .wr_free  (slot_free),
    .rd_valid (seed_valid),
    .rd_seed  (seed_data),
    .rd_tree  (rd_tree),
    .rd_k     (rd_k)
  );

  assign tree_start = (state == REQ);
  assign tree_t     = tree_cnt[TREE_IDX_W-1:0];
  assign seed_index = {rd_tree, rd_k};
  assign seed_last  = seed_valid && (rd_tree == LAST_TREE) && (rd_k == 2'd3);
  assign req_state  = state;
endmodule

// File: tb/tb_inseed_dispatcher.sv
// Bench for inseed_dispatcher: random-latency seed-tree model, random-stall consumer, queue reference.
module tb_inseed_dispatcher;
  import picnic_seed_pkg::*;

  localparam int NT    = 4;
  localparam int EXP_W = 1 + SEED_IDX_W + SEED_W;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  run_start;
  logic                  tree_start;
  logic [TREE_IDX_W-1:0] tree_t;
  logic                  tree_set_end;
  logic [INSEEDS_W-1:0]  inseeds;
  logic                  seed_valid;
  logic                  seed_ready;
  logic [SEED_W-1:0]     seed_data;
  logic [SEED_IDX_W-1:0] seed_index;
  logic                  seed_last;
  logic                  busy;
  logic                  done;
  req_state_t            req_state;

  int          checks = 0;
  int          errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  int          req_q[$];
  int          ready_mode = 0;
  logic [31:0] run_salt = '0;
  int          rise_bad = 0;
  int          done_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  inseed_dispatcher #(.NUM_TREES(NT)) dut (
    .clk          (clk),
    .reset        (reset),
    .run_start    (run_start),
    .tree_start   (tree_start),
    .tree_t       (tree_t),
    .tree_set_end (tree_set_end),
    .inseeds      (inseeds),
    .seed_valid   (seed_valid),
    .seed_ready   (seed_ready),
    .seed_data    (seed_data),
    .seed_index   (seed_index),
    .seed_last    (seed_last),
    .busy         (busy),
    .done         (done),
    .req_state    (req_state)
  );

  function automatic logic [SEED_W-1:0] word_of(input int t, input int k, input logic [31:0] salt);
    logic [SEED_W-1:0] w;
    for (int j = 0; j < 8; j++) w[j*32 +: 32] = salt ^ 32'(t * 4 + k) ^ (32'(j) << 24);
    return w;
  endfunction

  task automatic check(input string tag, input logic [EXP_W-1:0] got, input logic [EXP_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tree_start"}, EXP_W'(tree_start), '0);
    check({tag, "_tree_t"},     EXP_W'(tree_t),     '0);
    check({tag, "_seed_valid"}, EXP_W'(seed_valid), '0);
    check({tag, "_seed_data"},  EXP_W'(seed_data),  '0);
    check({tag, "_seed_index"}, EXP_W'(seed_index), '0);
    check({tag, "_seed_last"},  EXP_W'(seed_last),  '0);
    check({tag, "_busy"},       EXP_W'(busy),       '0);
    check({tag, "_done"},       EXP_W'(done),       '0);
  endtask

  // Reference: trees 0..NT-1 in order, four inseeds each, last flag on the very final one.
  task automatic start_run(input logic [31:0] salt);
    run_salt = salt;
    req_q.delete();
    for (int t = 0; t < NT; t++)
      for (int k = 0; k < 4; k++)
        exp_q.push_back({(t == NT - 1) && (k == 3), SEED_IDX_W'(t * 4 + k), word_of(t, k, salt)});
    @(negedge clk);
    run_start = 1'b1;
    @(negedge clk);
    run_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int start_cnt;
    start_cnt = done_cnt;
    for (int i = 0; (i < 600) && (done_cnt == start_cnt); i++) @(negedge clk);
    check({tag, "_done_seen"}, EXP_W'(done_cnt != start_cnt), EXP_W'(1));
    check({tag, "_all_seeds"}, EXP_W'(exp_q.size()), '0);
    check({tag, "_req_count"}, EXP_W'(req_q.size()), EXP_W'(NT));
    for (int i = 0; (i < req_q.size()) && (i < NT); i++)
      check($sformatf("%s_req_tree_%0d", tag, i), EXP_W'(req_q[i]), EXP_W'(i));
  endtask

  // Seed-tree model: random latency, result held a random while after tree_start drops.
  initial begin : tree_model
    int   lat;
    int   hold;
    logic prev_ts;
    lat = 0;
    hold = 0;
    prev_ts = 1'b0;
    tree_set_end = 1'b0;
    inseeds = '0;
    forever begin
      @(negedge clk);
      if (tree_start && !prev_ts) begin
        req_q.push_back(int'(tree_t));
        if (tree_set_end) rise_bad++;
        lat = $urandom_range(0, 4);
      end
      prev_ts = tree_start;
      if (!tree_start) begin
        if (hold > 0) hold--;
        else tree_set_end = 1'b0;
      end else if (!tree_set_end) begin
        if (lat > 0) begin
          lat--;
        end else begin
          inseeds = {word_of(int'(tree_t), 0, run_salt), word_of(int'(tree_t), 1, run_salt),
                     word_of(int'(tree_t), 2, run_salt), word_of(int'(tree_t), 3, run_salt)};
          tree_set_end = 1'b1;
          hold = $urandom_range(0, 2);
        end
      end
    end
  end

  // Consumer and scoreboard: drives seed_ready, checks each transfer against exp_q.
  initial begin : consumer
    logic [EXP_W-1:0] exp_item;
    logic [EXP_W-1:0] held;
    logic hold_valid;
    logic done_due;
    logic cap_due;
    hold_valid = 1'b0;
    done_due = 1'b0;
    cap_due = 1'b0;
    held = '0;
    seed_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       seed_ready = 1'b1;
        1:       seed_ready = ($urandom_range(0, 3) != 0);
        default: seed_ready = 1'b0;
      endcase
      #1;
      if (!reset) begin
        hold_valid = 1'b0;
        done_due = 1'b0;
        cap_due = 1'b0;
        continue;
      end
      if (done) done_cnt++;
      if (done_due) begin
        check("done_after_last", EXP_W'(done), EXP_W'(1));
        check("busy_low_at_done", EXP_W'(busy), '0);
        done_due = 1'b0;
      end
      if (cap_due) begin
        check("valid_after_capture", EXP_W'(seed_valid), EXP_W'(1));
        check("drop_after_capture", EXP_W'(tree_start), '0);
        cap_due = 1'b0;
      end
      if (hold_valid) begin
        check("stall_valid_held", EXP_W'(seed_valid), EXP_W'(1));
        check("stall_fields_held", {seed_last, seed_index, seed_data}, held);
      end
      if (tree_start && tree_set_end && !seed_valid) cap_due = 1'b1;
      hold_valid = 1'b0;
      if (seed_valid && seed_ready) begin
        check("seed_expected", EXP_W'(exp_q.size() > 0), EXP_W'(1));
        if (exp_q.size() > 0) begin
          exp_item = exp_q.pop_front();
          check("seed_index", EXP_W'(seed_index), EXP_W'(exp_item[EXP_W-2 -: SEED_IDX_W]));
          check("seed_data", EXP_W'(seed_data), EXP_W'(exp_item[SEED_W-1:0]));
          check("seed_last", EXP_W'(seed_last), EXP_W'(exp_item[EXP_W-1]));
          if (exp_item[EXP_W-1]) done_due = 1'b1;
        end
      end else if (seed_valid) begin
        held = {seed_last, seed_index, seed_data};
        hold_valid = 1'b1;
      end
    end
  end

  initial begin : stimulus
    logic found;
    reset = 1'b0;
    run_start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;

    // Full-rate run with start latency checks.
    ready_mode = 0;
    start_run(32'h1000_0000);
    check("start_busy_cycle1", EXP_W'(busy), EXP_W'(1));
    check("start_no_req_cycle1", EXP_W'(tree_start), '0);
    @(negedge clk);
    check("start_req_cycle2", EXP_W'(tree_start), EXP_W'(1));
    check("start_tree_t0", EXP_W'(tree_t), '0);
    wait_done("run1");

    // Downstream stalled: both slots fill, no third request.
    ready_mode = 2;
    start_run(32'h2000_0000);
    repeat (40) @(negedge clk);
    check("stall_req_count", EXP_W'(req_q.size()), EXP_W'(2));
    check("stall_valid", EXP_W'(seed_valid), EXP_W'(1));
    check("stall_index", EXP_W'(seed_index), '0);
    ready_mode = 0;
    wait_done("stall");

    // Random stalls plus a run_start pulse while busy.
    ready_mode = 1;
    start_run(32'h3000_0000);
    repeat (12) @(negedge clk);
    check("busy_before_restart", EXP_W'(busy), EXP_W'(1));
    run_start = 1'b1;
    @(negedge clk);
    run_start = 1'b0;
    check("busy_after_restart", EXP_W'(busy), EXP_W'(1));
    wait_done("restart");

    // Reset while tree 2 is being dispatched, then a fresh run.
    start_run(32'h4000_0000);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (seed_valid && (seed_index[SEED_IDX_W-1:2] == 8'd2)) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_tree2", EXP_W'(found), EXP_W'(1));
    #1 reset = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    start_run(32'h5000_0000);
    wait_done("after_reset");

    check("no_rise_while_end", EXP_W'(rise_bad), '0);
    check("done_pulses", EXP_W'(done_cnt), EXP_W'(4));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inseed_dispatcher.md
# inseed_dispatcher

Sits directly downstream of the seed-tree expander and drives its request side for one signature. Issues one tree request per round batch with the tree index on `tree_t`, and captures each 1024-bit `inseeds` result into a two-slot ping-pong buffer. Streams the individual 256-bit inseeds, one per valid/ready handshake, to the per-round party-seed stage. Tree expansion of batch n+1 overlaps dispatch of batch n.

## Interface
- `NUM_TREES`, default 64: trees per signature; legal range 1..256.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `run_start` in 1: one-cycle pulse that starts a signature; ignored while `busy`=1.
- `tree_start` out 1: level request to the seed tree.
- `tree_t` out 8: index of the tree being requested, 0..NUM_TREES-1.
- `tree_set_end` in 1: seed-tree completion level; stays high until `tree_start` drops.
- `inseeds` in 1024: seed-tree result; valid while `tree_set_end`=1.
- `seed_valid` out 1: `seed_data` holds an inseed.
- `seed_ready` in 1: downstream accepts when high together with `seed_valid`.
- `seed_data` out 256: current inseed.
- `seed_index` out 10: global inseed number, {tree[7:0], k[1:0]}.
- `seed_last` out 1: high with the final inseed of the signature.
- `busy` out 1: high from the cycle after an accepted `run_start` until `done`.
- `done` out 1: one-cycle pulse after the last handshake.

## Operation
- Request FSM states:
  - IDLE: on `run_start`, tree counter := 0, go to ARB.
  - ARB: if a slot is free and trees remain, go to REQ; if all trees have been requested, stay until the dispatch side drains.
  - REQ: `tree_start`=1. When `tree_set_end`=1, write `inseeds` into the free slot tagged with its tree index, increment the tree counter, go to DROP.
  - DROP: `tree_start`=0. Wait until `tree_set_end` reads 0, then go to ARB. Never reassert `tree_start` while `tree_set_end` is still high.
- Dispatch side:
  - Slots are consumed in capture order.
  - Inseed order within a slot: k=0 is `inseeds[1023:768]`, then [767:512], [511:256], and k=3 is [255:0].
  - `seed_data`, `seed_index` and `seed_last` hold stable while `seed_valid`=1 and `seed_ready`=0.
  - On a handshake, k increments. The handshake on k=3 frees the slot and moves dispatch to the other slot if it is full; otherwise `seed_valid` drops.
- `seed_last` = (tree == NUM_TREES-1) && (k == 3).
- `done` pulses the cycle after the `seed_last` handshake. `busy` falls in the same cycle and the FSM returns to IDLE.
- Simultaneous events: a capture into one slot and the free of the other slot in the same cycle are both honoured. A slot freed this cycle is not reused for capture until the next cycle (ARB sees it then).
- `run_start` while `busy` is ignored, with no side effects.
- Reset mid-operation: all outputs return to reset values and both slots are marked empty. The upstream tree is released by `tree_start`=0.

## Timing
- Reset values: `tree_start`=0, `tree_t`=0, `seed_valid`=0, `seed_data`=0, `seed_index`=0, `seed_last`=0, `busy`=0, `done`=0.
- `run_start` at cycle 0: `busy`=1 at cycle 1 and `tree_start`=1 at cycle 2 (IDLE→ARB→REQ).
- `tree_set_end` sampled 1 at cycle c:
  - slot written at edge c;
  - `tree_start`=0 from c+1;
  - `seed_valid`=1 from c+1 if dispatch was idle.
- Throughput: 1 inseed per cycle with `seed_ready` held high. No bubble between slots when the next slot is already full.
- `tree_t` is registered and stable throughout REQ.

## Structure
- Package `picnic_seed_pkg` holds:
  - SEED_W=256, SEEDS_PER_TREE=4, INSEEDS_W=1024, TREE_IDX_W=8, SEED_IDX_W=10;
  - request-FSM state enum {IDLE, ARB, REQ, DROP}.
- Sub-module `inseed_slot_buffer` is the 2×1024-bit ping-pong store with full flags, write/read pointers and the k counter. The top level holds the request FSM and the handshake outputs.

## Test plan
- NUM_TREES=1; model the tree with 5-cycle latency and inseeds = 1024'h00..01..02..03 words; `seed_ready`=1 → 4 handshakes with seed_index 0,1,2,3 and data words in order; `seed_last` on index 3; `done` one cycle later.
- NUM_TREES=4, ready always 1 → `tree_t` goes 0,1,2,3; 16 consecutive seeds with seed_index 0..15; `tree_start` never high while `tree_set_end` is still 1.
- NUM_TREES=3, `seed_ready`=0 for 40 cycles → both slots fill, and no third `tree_start` until a slot is freed; `seed_data` is held stable throughout.
- Random `seed_ready` stall pattern, NUM_TREES=8 → all 32 seeds delivered in order with no duplicates or drops, and `seed_last` only on index 31.
- `run_start` pulse while `busy` → no restart; `tree_t` sequence unchanged.
- `reset` low during tree 2 dispatch → all outputs reset next cycle, `tree_start`=0; a fresh `run_start` restarts at `tree_t`=0, seed_index 0.
